// File: rtl/run_control_unit.sv
// Front-panel run controller: turns next/run/speed_run levels into CPU clock-enable pulses,
// counts executed instructions and registers one monitor channel. Option: BREAKPOINT_EN.
module run_control_unit #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_CH   = 16,
    parameter int unsigned SLOW_DIV = 1000,
    parameter int unsigned FAST_DIV = 4,
    parameter int unsigned ICNT_W   = 16,
    localparam int unsigned SelW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     next,
    input  logic                     run,
    input  logic                     speed_run,
    input  logic                     halt_req,
    input  logic [NUM_CH*DATA_W-1:0] mon_bus,
    input  logic [SelW-1:0]          mon_sel,
`ifdef BREAKPOINT_EN
    input  logic                     bp_valid,
    input  logic [7:0]               bp_addr,
    input  logic [7:0]               pc,
    output logic                     bp_hit,
`endif
    output logic                     cpu_en,
    output logic [2:0]               mode,
    output logic [ICNT_W-1:0]        icount,
    output logic [DATA_W-1:0]        mon_out
);

    localparam int unsigned DivW = $clog2(SLOW_DIV);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStep   = 3'd1,
        StRun    = 3'd2,
        StFast   = 3'd3,
        StHalted = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          btn_q, btn_d, rise;
    logic [DivW-1:0]     div_q, div_d;
    logic [ICNT_W-1:0]   icount_q, icount_d;
    logic [DATA_W-1:0]   mon_q, mon_d;
    logic                div_wrap, running, bp_stop;

    assign btn_d   = {speed_run, run, next};
    assign rise    = btn_d & ~btn_q;
    assign running = (state_q == StRun) || (state_q == StFast);

    always_comb begin
        div_wrap = 1'b0;
        if (state_q == StRun && div_q == DivW'(SLOW_DIV - 1)) div_wrap = 1'b1;
        if (state_q == StFast && div_q == DivW'(FAST_DIV - 1)) div_wrap = 1'b1;
        cpu_en = !halt_req && ((state_q == StStep) || div_wrap);
    end

`ifdef BREAKPOINT_EN
    assign bp_stop = running && cpu_en && bp_valid && (pc == bp_addr);
    assign bp_hit  = bp_stop;
`else
    assign bp_stop = 1'b0;
`endif

    // Edge bits: [2] speed_run, [1] run, [0] next. halt_req overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rise[2])      state_d = StFast;
                else if (rise[1]) state_d = StRun;
                else if (rise[0]) state_d = StStep;
            end
            StStep: state_d = StIdle;
            StRun: begin
                if (rise[1])      state_d = StIdle;
                else if (rise[2]) state_d = StFast;
            end
            StFast: begin
                if (rise[1])      state_d = StIdle;
                else if (rise[2]) state_d = StRun;
            end
            StHalted: begin
                if (rise[0])      state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (bp_stop)  state_d = StIdle;
        if (halt_req) state_d = StHalted;
    end

    always_comb begin
        div_d = '0;
        if (running && state_d == state_q && !div_wrap) div_d = div_q + DivW'(1);
        icount_d = icount_q;
        if (cpu_en && icount_q != '1) icount_d = icount_q + ICNT_W'(1);
        mon_d = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (mon_sel == SelW'(k)) mon_d = mon_bus[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        // Track levels even in reset so a button held through reset is not seen as an edge.
        btn_q <= btn_d;
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            icount_q <= '0;
            mon_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            icount_q <= icount_d;
            mon_q    <= mon_d;
        end
    end

    assign mode    = state_q;
    assign icount  = icount_q;
    assign mon_out = mon_q;

endmodule
